// File: rtl/fp_add_arbiter_if.sv
// Bundle of request, response and shared-adder signals for fp_add_arbiter.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed operands, requester i at [i*XLEN +: XLEN]
//   add_a/add_b         : operands to the shared combinational adder
//   add_result          : adder sum, combinational from add_a/add_b
//   rsp_valid/rsp_ready : per-requester result handshake
//   rsp_data            : result shared by all response channels
//   busy                : arbiter is not idle
// slave is the arbiter side; master is the environment (requesters + adder).
interface fp_add_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [XLEN-1:0]      add_a;
  logic [XLEN-1:0]      add_b;
  logic [XLEN-1:0]      add_result;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [XLEN-1:0]      rsp_data;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_result,
    input  req_ready, rsp_valid, rsp_data, add_a, add_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_result,
    output req_ready, rsp_valid, rsp_data, add_a, add_b, busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among
// NREQ requesters. One operation in flight: IDLE (grant) -> EXEC (adder
// evaluates) -> RESP (hold result until the owner accepts it).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_add_arbiter_if.slave (request, response and adder signals)
// Operand pairs with a zero operand or exact cancellation are resolved here
// and never reach the adder; add_a/add_b keep their previous values then.
module fp_add_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  fp_add_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [XLEN-1:0] add_a_q, add_a_d;
  logic [XLEN-1:0] add_b_q, add_b_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic            win_found;
  logic [PtrW-1:0] win_idx;
  logic [XLEN-1:0] win_a, win_b;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;

  // Pairs the adder must not see: a zero operand or exact cancellation.
  function automatic logic is_bypass(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (a[XLEN-2:0] == '0) || (b[XLEN-2:0] == '0) ||
           ((a[XLEN-2:0] == b[XLEN-2:0]) && (a[XLEN-1] != b[XLEN-1]));
  endfunction

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned     cand;
    logic [PtrW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PtrW'(cand);
      if (!win_found && bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_a = bus.req_a[win_idx*XLEN +: XLEN];
  assign win_b = bus.req_b[win_idx*XLEN +: XLEN];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          op_a_d  = win_a;
          op_b_d  = win_b;
          idx_d   = win_idx;
          // Load the adder inputs at grant so they are stable throughout EXEC.
          if (!is_bypass(win_a, win_b)) begin
            add_a_d = win_a;
            add_b_d = win_b;
          end
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_a_q[XLEN-2:0] == '0) begin
          rsp_data_d = op_b_q;
        end else if (op_b_q[XLEN-2:0] == '0) begin
          rsp_data_d = op_a_q;
        end else if ((op_a_q[XLEN-2:0] == op_b_q[XLEN-2:0]) &&
                     (op_a_q[XLEN-1] != op_b_q[XLEN-1])) begin
          rsp_data_d = '0;
        end else begin
          rsp_data_d = bus.add_result;
        end
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready[idx_q]) begin
          state_d = StIdle;
          ptr_d   = (idx_q == PtrW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if ((state_q == StIdle) && win_found) req_ready[win_idx] = 1'b1;
    if (state_q == StResp) rsp_valid[idx_q] = 1'b1;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model. The shared adder is
// modelled here with real arithmetic.
module tb_fp_add_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fp_add_arbiter_if #(.XLEN(32), .NREQ(N)) bus ();

  fp_add_arbiter #(.XLEN(32), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single <-> double conversion for normal numbers and zero.
  function automatic real sp2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:0] == 31'd0) return 0.0;
    d = {a[31], 11'({3'd0, a[30:23]} + 11'd896), a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  always_comb bus.add_result = sp_add(bus.add_a, bus.add_b);

  // Expected result of one operation from the operand-pair rules.
  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:0] == b[30:0] && a[31] != b[31]) return 32'h0;
    return sp_add(a, b);
  endfunction

  function automatic bit skips_adder(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 31'd0) || (b[30:0] == 31'd0) || (a[30:0] == b[30:0] && a[31] != b[31]);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(145, 110)), 23'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", bus.rsp_valid); end
    total++; if (bus.add_a !== 32'h0) begin bad++; $display("FAIL reset_add_a got=%h want=0", bus.add_a); end
    // Put an operation into RESP, then reset it away.
    set_op(2, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL pre_reset_rsp got=%b want=0100", bus.rsp_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL async_rsp_valid got=%b want=0000", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL async_rsp_data got=%h want=0", bus.rsp_data); end
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_req_ready got=%b want=0001", bus.req_ready); end
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL no_rsp_after_reset got=%b want=0000", bus.rsp_valid); end
  endtask

  task automatic test_single();
    do_reset();
    bus.rsp_ready = 4'b1111;
    set_op(2, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_exec got=%b want=1", bus.busy); end
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL single_exec_ready got=%b want=0000", bus.req_ready); end
    total++; if (bus.add_b !== 32'h4000_0000) begin bad++; $display("FAIL single_add_b got=%h want=40000000", bus.add_b); end
    tick();
    total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid got=%b want=0100", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h4040_0000) begin bad++; $display("FAIL single_rsp_data got=%h want=40400000", bus.rsp_data); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_resp got=%b want=1", bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%b want=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int g[$];
    int gc[$];
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'h3F80_0000, 32'h3F80_0000);
    bus.rsp_ready = 4'b1111;
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 40 && g.size() < 5; c++) begin
      if (bus.req_ready != 4'b0) begin
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) g.push_back(i);
        gc.push_back(c);
      end
      if (bus.rsp_valid != 4'b0) begin
        total++; if (bus.rsp_data !== 32'h4000_0000) begin bad++; $display("FAIL rr_data got=%h want=40000000", bus.rsp_data); end
      end
      tick();
    end
    bus.req_valid = '0;
    total++; if (g.size() != 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", g.size()); end
    for (int i = 0; i < 5 && i < g.size(); i++) begin
      total++; if (g[i] != want[i]) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, g[i], want[i]); end
      if (i > 0) begin
        total++; if (gc[i] - gc[i-1] != 3) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d want=3", i, gc[i] - gc[i-1]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_op(1, 32'h3F80_0000, 32'h4000_0000);
    set_op(0, 32'h3F80_0000, 32'h3F80_0000);
    bus.rsp_ready = 4'b0001;
    bus.req_valid = 4'b0010;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b want=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.rsp_valid !== 4'b0010) begin bad++; $display("FAIL bp_rsp_valid[%0d] got=%b want=0010", c, bus.rsp_valid); end
      total++; if (bus.rsp_data !== 32'h4040_0000) begin bad++; $display("FAIL bp_rsp_data[%0d] got=%h want=40400000", c, bus.rsp_data); end
      total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b want=0000", c, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 4'b0011;
    tick();
    total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL bp_complete got=%b want=0000", bus.rsp_valid); end
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b want=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_bypass();
    logic [31:0] ta[3] = '{32'h0000_0000, 32'hC0A0_0000, 32'h40A0_0000};
    logic [31:0] tb[3] = '{32'h40A0_0000, 32'h0000_0000, 32'hC0A0_0000};
    logic [31:0] tr[3] = '{32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000};
    do_reset();
    bus.rsp_ready = 4'b1111;
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      set_op(i + 1, ta[i], tb[i]);
      bus.req_valid = 4'(1 << (i + 1));
      tick();
      bus.req_valid = '0;
      #1;
      total++; if (bus.add_a !== 32'h3F80_0000) begin bad++; $display("FAIL byp_add_a[%0d] got=%h want=3f800000", i, bus.add_a); end
      total++; if (bus.add_b !== 32'h4000_0000) begin bad++; $display("FAIL byp_add_b[%0d] got=%h want=40000000", i, bus.add_b); end
      tick();
      total++; if (bus.rsp_data !== tr[i]) begin bad++; $display("FAIL byp_data[%0d] got=%h want=%h", i, bus.rsp_data, tr[i]); end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.rsp_ready = 4'b1111;
    set_op(3, 32'h3F80_0000, 32'h3F80_0000);
    set_op(0, 32'h4000_0000, 32'h3F80_0000);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.req_valid = 4'b1001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b want=0001", bus.req_ready); end
    tick();
    tick();
    tick();
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_next got=%b want=1000", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  // Random traffic against a transaction-level model: at most one operation
  // outstanding, tracked as (owner, operands, age since grant).
  task automatic test_random();
    int          m_ptr = 0;
    int          m_own = -1;
    int          m_age = 0;
    logic [31:0] m_a = '0, m_b = '0, m_add_a = '0, m_add_b = '0, m_data = '0;
    logic [N-1:0] e_rdy, e_vld;
    int          w;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        a = rand_fp();
        b = rand_fp();
        case ($urandom % 8)
          0: a = ($urandom % 2 != 0) ? 32'h8000_0000 : 32'h0;
          1: b = ($urandom % 2 != 0) ? 32'h8000_0000 : 32'h0;
          2: b = {~a[31], a[30:0]};
          default: ;
        endcase
        set_op(i, a, b);
      end
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom % 4 != 0);
      #1;
      w = (m_own < 0) ? rr_pick(bus.req_valid, m_ptr) : -1;
      e_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
      e_vld = (m_own >= 0 && m_age >= 2) ? 4'(1 << m_own) : 4'b0;
      total++; if (bus.req_ready !== e_rdy) begin bad++; $display("FAIL rnd_req_ready c=%0d got=%b want=%b", c, bus.req_ready, e_rdy); end
      total++; if (bus.rsp_valid !== e_vld) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b want=%b", c, bus.rsp_valid, e_vld); end
      total++; if (bus.busy !== (m_own >= 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, bus.busy, m_own >= 0); end
      total++; if (bus.rsp_data !== m_data) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%h want=%h", c, bus.rsp_data, m_data); end
      total++; if (bus.add_a !== m_add_a || bus.add_b !== m_add_b) begin
        bad++; $display("FAIL rnd_add_ops c=%0d got=%h,%h want=%h,%h", c, bus.add_a, bus.add_b, m_add_a, m_add_b);
      end
      // Advance the model with the inputs present at this edge.
      if (w >= 0) begin
        m_own = w;
        m_age = 0;
        m_a   = bus.req_a[w*32 +: 32];
        m_b   = bus.req_b[w*32 +: 32];
        if (!skips_adder(m_a, m_b)) begin
          m_add_a = m_a;
          m_add_b = m_b;
        end
      end else if (m_own >= 0 && m_age == 1) begin
        m_data = exp_res(m_a, m_b);
      end else if (m_own >= 0 && m_age >= 2 && bus.rsp_ready[m_own]) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
      tick();
      if (m_own >= 0) m_age++;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_bypass();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter that shares one combinational single-precision floating-point adder among `NREQ` requesters. Each requester presents an operand pair over a valid/ready handshake. The block serialises accepted operations through the shared adder and returns the result to the originating requester over a per-requester valid/ready response channel. Operand pairs the adder cannot handle (zero operands, exact cancellation) are resolved locally and never sent to the adder.

## Interface
- `XLEN`, 32, operand/result width (IEEE-754 single; only 32 supported)
- `NREQ`, 4, number of requesters (2..8)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_ready`  out  NREQ  request accepted (one-hot or zero)
- `req_a`  in  NREQ*XLEN  operand A; requester i occupies bits [i*XLEN +: XLEN]
- `req_b`  in  NREQ*XLEN  operand B, same packing
- `add_a`  out  XLEN  operand A to shared adder
- `add_b`  out  XLEN  operand B to shared adder
- `add_result`  in  XLEN  shared adder sum (combinational from `add_a`/`add_b`)
- `rsp_valid`  out  NREQ  response valid (one-hot or zero)
- `rsp_ready`  in  NREQ  response accepted, one bit per requester
- `rsp_data`  out  XLEN  result, shared by all response channels
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Round-robin pointer `ptr` (log2 NREQ bits).
  - Winner = first i with `req_valid[i]`, searching ptr, ptr+1, ... with modulo-NREQ wrap.
- IDLE:
  - `req_ready` = one-hot winner (Mealy output, combinational from `req_valid` and `ptr`); zero if no request.
  - On handshake: latch `req_a`/`req_b` into operand registers, latch winner index into `idx`, go to EXEC.
- EXEC, exactly one cycle:
  - `add_a`/`add_b` are driven from the operand registers.
  - At the end of the cycle, capture the result into `rsp_data` by priority:
    - A[30:0]==0 → B
    - else B[30:0]==0 → A
    - else A[30:0]==B[30:0] and A[31]!=B[31] → 32'h0000_0000
    - else `add_result`
  - Go to RESP.
- In the three bypass cases, `add_a`/`add_b` hold their previous values and are not updated to the new operands. This keeps the adder's normalisation away from zero operands.
- RESP:
  - `rsp_valid[idx]`=1.
  - When `rsp_ready[idx]` is high, go to IDLE and set `ptr` = idx+1 mod NREQ.
  - `rsp_ready` bits other than `idx` are ignored.
- `req_ready` is zero in EXEC and RESP.
- `rsp_data`, `add_a`, `add_b` hold their values outside their update points.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, ptr=0, idx=0
  - operand registers, `add_a`, `add_b`, `rsp_data` = 0
  - `rsp_valid`=0, `busy`=0
  - `req_ready` follows the IDLE rule immediately.
- Latency: handshake at edge N → `rsp_valid` high from edge N+2 (after EXEC).
- Throughput: at most one operation per 3 cycles when responses are accepted immediately.
  - No request is accepted in the cycle `rsp_ready` completes; the next acceptance is the following IDLE cycle.
- `req_valid` may drop without handshake; no state change.
- Requester i may hold `req_valid` through its own pending operation. After its response completes, the pointer has moved past i, so other valid requesters are served first.
- Back-pressure: RESP is held indefinitely with `rsp_valid`/`rsp_data` stable while `rsp_ready[idx]`=0.
- Reset mid-operation discards the in-flight operation; no response is issued.
- Ptr wrap: idx=NREQ-1 → ptr=0.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-RESP → `rsp_valid`=0, `busy`=0, `rsp_data`=0 asynchronously; after release, the first request is from requester 0.
- **Single request:** requester 2 sends A=3F800000, B=40000000 (1.0+2.0) with `rsp_ready` tied high.
  - Expect `req_ready`=0100 in the handshake cycle.
  - Expect `rsp_valid`=0100 and `rsp_data`=40400000 two cycles later; `busy` high for 2 cycles.
- **Round-robin fairness:** all four `req_valid` held high, 1.0+1.0 each, `rsp_ready` high.
  - Grant order 0,1,2,3,0; each response is 40000000; grants spaced 3 cycles apart.
- **Back-pressure:** requester 1 request, `rsp_ready[1]` low for 5 cycles while `rsp_ready[0]` is high.
  - Expect `rsp_valid[1]` and `rsp_data` stable for all 5 cycles, `req_ready` all zero, completion on the cycle `rsp_ready[1]` rises.
- **Bypass cases:**
  - 00000000+40A00000 → 40A00000
  - C0A00000+00000000 → C0A00000
  - 40A00000+C0A00000 → 00000000
  - In all three, `add_a`/`add_b` are unchanged from the previous operation.
- **Pointer wrap:** requester 3 served, then requesters 0 and 3 both valid → requester 0 granted first.
